ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit for the execute stage, directly downstream of the ID/EX pipeline register. It consumes the operands latched by ID/EX for RV M-extension ops and computes the result over multiple cycles. While it computes, it holds the pipeline through the stall controller (`stallreq_o`, which drives `stall[3]` and freezes ID/EX). It presents the result for exactly one cycle, in which the EX stage writes it back.

## Interface
- `XLEN`, 64, operand/result width (matches `MXLEN`)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_i`  in  1  EX holds an M-extension op (ID/EX aluop decodes to MULDIV)
- `op_i`  in  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
- `word_i`  in  1  *W variant (see Configuration)
- `rs1_i`  in  XLEN  operand 1 (ID/EX `ex_reg1_o`)
- `rs2_i`  in  XLEN  operand 2 (ID/EX `ex_reg2_o`)
- `annul_i`  in  1  flush; abandon the current op
- `result_o`  out  XLEN  result; valid only when `ready_o`=1
- `ready_o`  out  1  single-cycle done strobe
- `stallreq_o`  out  1  stall request to the stall controller

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: `result_o`=0, `ready_o`=0, `stallreq_o`=0. The counter and all working registers are cleared.
- IDLE, `start_i`=1, normal case:
  - Latch absolute operand values and the result-sign flags.
  - Set count=0 and go to CALC.
- IDLE, `start_i`=1, special case: go directly to DONE with a fixed result.
  - DIV/DIVU with divisor 0 → quotient all-ones.
  - REM/REMU with divisor 0 → remainder = dividend.
  - Signed overflow (DIV/REM with most-negative / -1) → quotient = dividend, remainder = 0.
- CALC:
  - Multiply: one shift-add step per cycle over a 2·XLEN product.
  - Divide: one restoring shift-subtract step per cycle.
  - When count reaches N-1 (N = XLEN, or 32 for word ops), go to DONE.
- DONE:
  - Apply negation if required and drive `result_o`.
  - `ready_o`=1 for this cycle only, then unconditionally go to IDLE.
- Result selection:
  - MUL → low half of the product.
  - MULH/MULHSU/MULHU → high half.
  - DIV* → quotient.
  - REM* → remainder.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - DIV/REM: signed. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - All other ops: unsigned.
- `stallreq_o` = (IDLE & `start_i` & !`annul_i`) | CALC. It is 0 in DONE, so ID/EX advances on the DONE clock edge. The next IDLE cycle therefore sees a new instruction; the same op is never restarted.
- `annul_i`=1 in any state → IDLE next cycle. `ready_o` is not asserted for the annulled op. `result_o` holds its previous value.
- `rst` mid-operation → IDLE, partial results discarded.
- `result_o` holds its value between DONE cycles.

## Timing
- Start cycle T (IDLE with `start_i`=1).
- Normal op: CALC occupies T+1..T+N; DONE is at T+N+1. `stallreq_o` is high T..T+N (N+1 cycles).
- Special case: DONE at T+1; `stallreq_o` is high in T only.
- `ready_o` and `result_o` are registered-state outputs, valid in the DONE cycle. There is no combinational path from the inputs to `result_o`.
- Operands are sampled only in IDLE. Changes on `rs1_i`/`rs2_i`/`op_i` during CALC are ignored.

## Configuration
- `MULDIV_W_EN` defined:
  - `word_i`=1 with MUL/DIV/DIVU/REM/REMU executes MULW/DIVW/DIVUW/REMW/REMUW.
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended otherwise.
  - N=32.
  - Special-case checks use 32-bit values (divide by zero; 0x8000_0000 / -1).
  - The result is the low 32 bits of the computed value, sign-extended to XLEN.
  - `word_i` with MULH* is ignored.
- `MULDIV_W_EN` undefined: `word_i` is ignored and all ops are XLEN-wide with N=XLEN.

## Structure
- The funct3 op codes (`MULDIV_MUL` … `MULDIV_REMU`) and the FSM state encodings go in the shared `constant.v`.
- Sub-module `muldiv_datapath` contains:
  - operand absolute-value logic
  - the shift-add/shift-subtract step registers
  - final negation
- The top level holds the FSM, counter, special-case detection and the stall/ready logic.

## Test plan
- MUL, 7 × -3 (0xFFFF_FFFF_FFFF_FFFD) at T → `stallreq_o` high T..T+64; `ready_o` at T+65 with `result_o`=0xFFFF_FFFF_FFFF_FFEB.
- MULHU, 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE. MULHSU, -1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero, `rs1`=100, `rs2`=0:
  - DIV → `ready_o` at T+1, result 0xFFFF_FFFF_FFFF_FFFF.
  - REM → result 100.
  - In both cases `stallreq_o` is high only at T.
- Signed overflow, `rs1`=0x8000_0000_0000_0000, `rs2`=-1:
  - DIV → 0x8000_0000_0000_0000.
  - REM → 0.
  - Also REM -7 by 2 → 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU 100/7 started at T, `annul_i` at T+10 → `stallreq_o` low from T+11 and no `ready_o`. A new DIVU 100/7 at T+12 gives `ready_o` at T+77 with result 14.
- With `MULDIV_W_EN`: DIVW, `rs1`=0x1234_5678_FFFF_FFF9, `rs2`=2 → `ready_o` at T+33, result 0xFFFF_FFFF_FFFF_FFFD.
- Reset mid-CALC → IDLE, all outputs 0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_pkg
//  Description : Shared funct3 op codes, FSM state encoding, result-select
//                encoding and small decode helpers for the ex_muldiv unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    // funct3 codes of the RV M-extension ops
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    // Which part of the computed value becomes the result
    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_HI  = 2'd1,
        SEL_QUO = 2'd2,
        SEL_REM = 2'd3
    } res_sel_t;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
               (op == MULDIV_DIV)  || (op == MULDIV_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
    endfunction

    function automatic res_sel_t op_to_sel(input logic [2:0] op);
        res_sel_t sel;
        if (op[2])
            sel = op[1] ? SEL_REM : SEL_QUO;
        else
            sel = (op == MULDIV_MUL) ? SEL_LO : SEL_HI;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_datapath
//  Description : Working registers of the iterative multiplier/divider:
//                operand absolute value, one shift-add (multiply) or one
//                restoring shift-subtract (divide) step per cycle, and the
//                final sign correction / result selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [2:0]      i_op,
    input  logic            i_word,
    input  logic            i_a_signed,
    input  logic            i_b_signed,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    output logic [XLEN-1:0] o_result
);

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [XLEN-1:0]     w_quo_init;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN+1:0]     w_sub;
    logic                w_fits;
    logic                w_unused_sub_msb;
    logic [2*XLEN-1:0]   w_acc_add;
    logic [2*XLEN-1:0]   w_prod;

    logic [2*XLEN-1:0]   r_acc;      // product accumulator
    logic [2*XLEN-1:0]   r_mcand;    // multiplicand, shifted left each step
    logic [XLEN-1:0]     r_opb;      // multiplier (shifted right) or divisor
    logic [XLEN-1:0]     r_rem;      // partial remainder
    logic [XLEN-1:0]     r_quo;      // dividend shifting out / quotient in
    logic                r_neg;      // final result must be negated
    logic                r_is_div;
    res_sel_t            r_sel;

    assign w_a_neg = i_a_signed & i_opa[XLEN-1];
    assign w_b_neg = i_b_signed & i_opb[XLEN-1];
    assign w_abs_a = w_a_neg ? -i_opa : i_opa;
    assign w_abs_b = w_b_neg ? -i_opb : i_opb;

    // Word divides run 32 steps, so the dividend starts MSB-aligned
    assign w_quo_init = i_word ? (w_abs_a << (XLEN - 32)) : w_abs_a;

    // Restoring divide: shift in next dividend bit, subtract if it fits
    assign w_rem_sh         = {r_rem, r_quo[XLEN-1]};
    assign w_sub            = {1'b0, w_rem_sh} - {2'b00, r_opb};
    assign w_fits           = ~w_sub[XLEN+1];
    assign w_unused_sub_msb = w_sub[XLEN];

    assign w_acc_add = r_opb[0] ? (r_acc + r_mcand) : r_acc;

    // Load operands on start, then advance one multiply or divide step per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_neg    <= 1'b0;
            r_is_div <= 1'b0;
            r_sel    <= SEL_LO;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_opb    <= w_abs_b;
            r_rem    <= '0;
            r_quo    <= w_quo_init;
            // Remainder follows the dividend sign; everything else the xor
            r_neg    <= (i_op[2] & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_is_div <= i_op[2];
            r_sel    <= op_to_sel(i_op);
        end else if (i_step) begin
            if (r_is_div) begin
                if (w_fits) begin
                    r_rem <= w_sub[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    r_rem <= w_rem_sh[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc   <= w_acc_add;
                r_mcand <= {r_mcand[2*XLEN-2:0], 1'b0};
                r_opb   <= {1'b0, r_opb[XLEN-1:1]};
            end
        end
    end

    assign w_prod = r_neg ? -r_acc : r_acc;

    // Sign-correct and pick the requested part of the computed value
    always_comb begin
        o_result = '0;
        case (r_sel)
            SEL_LO:  o_result = w_prod[XLEN-1:0];
            SEL_HI:  o_result = w_prod[2*XLEN-1:XLEN];
            SEL_QUO: o_result = r_neg ? -r_quo : r_quo;
            SEL_REM: o_result = r_neg ? -r_rem : r_rem;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative RV M-extension multiply/divide unit for the EX
//                stage. Holds the pipeline via stallreq_o while computing and
//                strobes ready_o for one cycle with the result.
//                Optional feature macro: MULDIV_W_EN (32-bit *W variants).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            annul_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    localparam int              CNT_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST_X = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_W = CNT_W'(31);

    muldiv_state_t    r_state;
    muldiv_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_word;
    logic             r_special;
    logic [XLEN-1:0]  r_special_val;
    logic [XLEN-1:0]  r_result;

    logic             w_word;
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic [XLEN-1:0]  w_opa;
    logic [XLEN-1:0]  w_opb;
    logic [XLEN-1:0]  w_int_min;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_val;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_last;
    logic [XLEN-1:0]  w_dp_result;
    logic [XLEN-1:0]  w_raw;
    logic [XLEN-1:0]  w_final;

`ifdef MULDIV_W_EN
    // Only MUL and the divide/remainder ops have word forms
    assign w_word = word_i & (op_i[2] | (op_i == MULDIV_MUL));
`else
    logic w_unused_word;
    assign w_unused_word = word_i;
    assign w_word        = 1'b0;
`endif

    assign w_is_div   = op_i[2];
    assign w_a_signed = op_a_signed(op_i);
    assign w_b_signed = op_b_signed(op_i);

    // Word ops take the low 32 bits, extended according to signedness
    always_comb begin
        w_opa = rs1_i;
        w_opb = rs2_i;
        if (w_word) begin
            w_opa = {{(XLEN-32){w_a_signed & rs1_i[31]}}, rs1_i[31:0]};
            w_opb = {{(XLEN-32){w_b_signed & rs2_i[31]}}, rs2_i[31:0]};
        end
    end

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign w_int_min  = w_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                               : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = w_is_div && (w_opb == '0);
    assign w_ovf      = w_is_div && !op_i[0] && (w_opa == w_int_min) && (w_opb == '1);
    assign w_special  = w_div_zero | w_ovf;

    // REM*: dividend on /0, zero on overflow; DIV*: all-ones on /0, dividend on overflow
    always_comb begin
        w_special_val = '0;
        if (op_i[1])
            w_special_val = w_div_zero ? w_opa : '0;
        else
            w_special_val = w_div_zero ? '1 : w_opa;
    end

    assign w_cnt_last = r_word ? CNT_LAST_W : CNT_LAST_X;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state, stall request and datapath load decode
    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    stallreq_o  = 1'b1;
                    w_accept    = 1'b1;
                    w_load      = !w_special;
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stallreq_o = 1'b1;
                if (r_cnt == w_cnt_last)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (annul_i)
            w_state_nxt = ST_IDLE;
    end

    // Step counter, per-op flags and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_word        <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_result      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt         <= '0;
                r_word        <= w_word;
                r_special     <= w_special;
                r_special_val <= w_special_val;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_DONE) && !annul_i)
                r_result <= w_final;
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (r_state == ST_CALC),
        .i_op       (op_i),
        .i_word     (w_word),
        .i_a_signed (w_a_signed),
        .i_b_signed (w_b_signed),
        .i_opa      (w_opa),
        .i_opb      (w_opb),
        .o_result   (w_dp_result)
    );

    assign w_raw   = r_special ? r_special_val : w_dp_result;
    assign w_final = r_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;

    // Outputs decode from registered state only
    assign ready_o  = (r_state == ST_DONE);
    assign result_o = (r_state == ST_DONE) ? w_final : r_result;

endmodule
`default_nettype wire
